// File: rtl/kernel_bc_pkg.sv
// Shared definitions for the kernel_bc write-back controller: FSM encoding and default widths.
package kernel_bc_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 16;
    localparam int unsigned DefCntWidth  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/kernel_bc_write_back_ctrl_outreg.sv
// One-entry valid/ready holding register for memory write requests.
module kernel_bc_write_back_ctrl_outreg #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  can_load_o
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A new word may enter when the slot is empty or its occupant leaves this cycle.
    assign can_load_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/kernel_bc_write_back_ctrl.sv
// Write-back controller: pops a start token, streams num_items result words to
// consecutive addresses from base_addr, then pulses done.
module kernel_bc_write_back_ctrl
    import kernel_bc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_empty_n,
    output logic                  start_read,
    input  logic                  start_dout,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_items,
    input  logic                  data_empty_n,
    output logic                  data_read,
    input  logic [DATA_WIDTH-1:0] data_dout,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  done,
    output logic                  idle
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  can_load;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // The token value carries no information.
    logic unused_start_dout;
    assign unused_start_dout = start_dout;

    assign wr_addr = base_q + ADDR_WIDTH'(cnt_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        start_read = 1'b0;
        data_read  = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_empty_n) begin
                    start_read = 1'b1;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                base_d  = base_addr;
                num_d   = num_items;
                cnt_d   = '0;
                state_d = (num_items == '0) ? StDone : StStream;
            end
            StStream: begin
                data_read = data_empty_n && (cnt_q < num_q) && can_load;
                if (data_read) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                if (cnt_d == num_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!mem_wr_valid || mem_wr_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Handshakes are suppressed while reset is held so nothing is consumed.
        if (reset) begin
            start_read = 1'b0;
            data_read  = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
        end
    end

    assign idle = (state_q == StIdle);

    kernel_bc_write_back_ctrl_outreg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outreg (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (data_read),
        .addr_i    (wr_addr),
        .data_i    (data_dout),
        .ready_i   (mem_wr_ready),
        .valid_o   (mem_wr_valid),
        .addr_o    (mem_wr_addr),
        .data_o    (mem_wr_data),
        .can_load_o(can_load)
    );

endmodule

// File: tb/tb_kernel_bc_write_back_ctrl.sv
// Directed bench for kernel_bc_write_back_ctrl with a FIFO model and a write scoreboard.
module tb_kernel_bc_write_back_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_empty_n = 1'b0;
    logic          start_read;
    logic          start_dout = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_items = '0;
    logic          data_empty_n = 1'b0;
    logic          data_read;
    logic [DW-1:0] data_dout = '0;
    logic          mem_wr_valid;
    logic          mem_wr_ready = 1'b0;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          done;
    logic          idle;

    always #5 clk = ~clk;

    kernel_bc_write_back_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_empty_n(start_empty_n),
        .start_read   (start_read),
        .start_dout   (start_dout),
        .base_addr    (base_addr),
        .num_items    (num_items),
        .data_empty_n (data_empty_n),
        .data_read    (data_read),
        .data_dout    (data_dout),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .done         (done),
        .idle         (idle)
    );

    logic [DW-1:0] fifo[$];
    logic [AW-1:0] sb_addr[$];
    logic [DW-1:0] sb_data[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int tokens = 0;
    int start_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int writes = 0;
    int first_wr = -1;
    int last_wr = -1;
    bit prev_hold = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, then account for what the DUT
    // will do at the next rising edge.
    task automatic cycle(input bit rdy, input bit stall, input bit rst);
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        reset         = rst;
        mem_wr_ready  = rdy;
        data_empty_n  = (fifo.size() > 0) && !stall;
        data_dout     = (fifo.size() > 0) ? fifo[0] : '0;
        start_empty_n = (tokens > 0);
        if (start_cyc >= 0 && cyc >= start_cyc + 2) begin
            base_addr = AW'($urandom);
            num_items = CW'($urandom);
        end
        #1;
        if (prev_hold && !rst) begin
            chk("hold_valid", 64'(mem_wr_valid), 64'(1));
            chk("hold_addr", 64'(mem_wr_addr), 64'(prev_addr));
            chk("hold_data", 64'(mem_wr_data), 64'(prev_data));
        end
        prev_hold = mem_wr_valid && !mem_wr_ready && !rst;
        prev_addr = mem_wr_addr;
        prev_data = mem_wr_data;
        if (data_read) begin
            chk("pop_nonempty", 64'(data_empty_n), 64'(1));
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        if (start_read) begin
            tokens--;
            start_cyc = cyc;
        end
        if (mem_wr_valid && mem_wr_ready && !rst) begin
            chk("write_expected", 64'(sb_addr.size() > 0), 64'(1));
            if (sb_addr.size() > 0) begin
                exp_a = sb_addr.pop_front();
                exp_d = sb_data.pop_front();
                chk("wr_addr", 64'(mem_wr_addr), 64'(exp_a));
                chk("wr_data", 64'(mem_wr_data), 64'(exp_d));
            end
            writes++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic run_job(input string tag, input logic [AW-1:0] base, input int num,
                           input logic [DW-1:0] d0, input bit toggle, input int stall_at);
        int k;
        bit stall;
        for (int i = 0; i < num; i++) begin
            fifo.push_back(d0 + DW'(i));
            sb_addr.push_back(base + AW'(i));
            sb_data.push_back(d0 + DW'(i));
        end
        fifo.push_back(32'hDEAD_BEEF);
        base_addr = base;
        num_items = CW'(num);
        tokens    = 1;
        start_cyc = -1;
        done_cnt  = 0;
        writes    = 0;
        first_wr  = -1;
        last_wr   = -1;
        k = 0;
        while (done_cnt == 0 && k < 300) begin
            stall = (stall_at >= 0) && (k >= stall_at) && (k < stall_at + 5);
            cycle(toggle ? k[0] : 1'b1, stall, 1'b0);
            k++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt), 64'(1));
        cycle(1'b1, 1'b0, 1'b0);
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
        chk({tag, "_idle_after"}, 64'(idle), 64'(1));
        chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
        chk({tag, "_writes"}, 64'(writes), 64'(num));
        chk({tag, "_sb_empty"}, 64'(sb_addr.size()), 64'(0));
        chk({tag, "_no_overpop"}, 64'(fifo.size()), 64'(1));
        fifo.delete();
        sb_addr.delete();
        sb_data.delete();
    endtask

    initial begin
        int k;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_valid", 64'(mem_wr_valid), 64'(0));
        chk("rst_start_read", 64'(start_read), 64'(0));
        chk("rst_data_read", 64'(data_read), 64'(0));
        chk("rst_done", 64'(done), 64'(0));

        run_job("basic", 16'h0010, 4, 32'h0000_000A, 1'b0, -1);
        chk("basic_back_to_back", 64'(last_wr - first_wr), 64'(3));

        run_job("zero", 16'h1234, 0, 32'h0, 1'b0, -1);
        chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'(2));

        run_job("toggle", 16'h0200, 3, 32'h0000_0100, 1'b1, -1);

        run_job("wrap", 16'hFFFE, 4, 32'h0000_0055, 1'b0, -1);

        run_job("stall", 16'h0300, 6, 32'h0000_0077, 1'b0, 3);

        // Abort a job while a write is held by a stalled memory.
        for (int i = 0; i < 3; i++) fifo.push_back(32'h0000_0500 + DW'(i));
        base_addr = 16'h0500;
        num_items = 16'd3;
        tokens    = 1;
        start_cyc = -1;
        done_cnt  = 0;
        k = 0;
        while (!mem_wr_valid && k < 20) begin
            cycle(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("abort_valid_seen", 64'(mem_wr_valid), 64'(1));
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("abort_rst_data_read", 64'(data_read), 64'(0));
        chk("abort_rst_done", 64'(done), 64'(0));
        cycle(1'b0, 1'b0, 1'b0);
        chk("abort_valid_cleared", 64'(mem_wr_valid), 64'(0));
        chk("abort_idle", 64'(idle), 64'(1));
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        fifo.delete();
        sb_addr.delete();
        sb_data.delete();

        run_job("post_rst", 16'h0040, 3, 32'h0000_0900, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_bc_write_back_ctrl.md
KERNEL_BC_WRITE_BACK_CTRL -- requirements
Module: kernel_bc_write_back_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of result words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, width of write address.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of per-job item count.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start_empty_n  in  1  start-token FIFO holds a token.
REQ-007 SHALL have port start_read  out  1  pop one start token.
REQ-008 SHALL have port start_dout  in  1  token value; ignored.
REQ-009 SHALL have port base_addr  in  ADDR_WIDTH  first write address of the job.
REQ-010 SHALL have port num_items  in  CNT_WIDTH  words in the job.
REQ-011 SHALL have port data_empty_n  in  1  result FIFO non-empty.
REQ-012 SHALL have port data_read  out  1  pop one result word.
REQ-013 SHALL have port data_dout  in  DATA_WIDTH  result word at the FIFO head.
REQ-014 SHALL have port mem_wr_valid  out  1  write request valid.
REQ-015 SHALL have port mem_wr_ready  in  1  memory accepts the request.
REQ-016 SHALL have port mem_wr_addr  out  ADDR_WIDTH  write address.
REQ-017 SHALL have port mem_wr_data  out  DATA_WIDTH  write data.
REQ-018 SHALL have port done  out  1  one-cycle pulse at job end.
REQ-019 SHALL have port idle  out  1  high in IDLE only.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, STREAM, DRAIN and DONE.
REQ-021 IDLE: start_read=1 when start_empty_n=1, then go to LOAD; start_read SHALL never assert outside IDLE.
REQ-022 LOAD (1 cycle): latch base_addr and num_items, clear item counter; go to DONE if num_items==0, else to STREAM.
REQ-023 STREAM: data_read = data_empty_n & (cnt<num) & (!mem_wr_valid | mem_wr_ready).
REQ-024 On data_read, the output register SHALL load addr=base+cnt (mod 2^ADDR_WIDTH) and data=data_dout, set mem_wr_valid=1 next cycle, and increment cnt.
REQ-025 mem_wr_valid/addr/data SHALL stay stable until mem_wr_ready; valid clears after acceptance unless reloaded in the same cycle (back-to-back, one word per cycle).
REQ-026 When cnt reaches num, STREAM SHALL go to DRAIN; DRAIN waits for the last request to be accepted, then goes to DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; a pending start token SHALL be popped in the following IDLE cycle at the earliest.
REQ-028 data_read SHALL never assert while data_empty_n=0, and no word beyond num_items SHALL be popped.
REQ-029 Address wrap-around past 2^ADDR_WIDTH-1 SHALL wrap silently to 0.
REQ-030 Changes on base_addr/num_items after LOAD SHALL not affect the running job.

Reset
REQ-031 During reset=1: FSM=IDLE, cnt=0, mem_wr_valid=0, start_read=0, data_read=0, done=0, idle=1 in the following cycle.
REQ-032 Reset mid-job SHALL abandon the job and drop the held write; no done pulse is issued.

Structure
REQ-033 The FSM state encoding and default widths SHALL live in the shared package kernel_bc_pkg.
REQ-034 The output holding register SHALL be a sub-module kernel_bc_write_back_ctrl_outreg (valid/ready one-entry skid register).

Verification
REQ-035 base=0x0010, num=4, data 0xA..0xD, ready=1: writes 0x10..0x13 on 4 consecutive cycles, done once.
REQ-036 num=0 with a token: token popped, no write, done pulse 2 cycles after start_read.
REQ-037 ready toggling 1/0 each cycle, num=3: addr/data held while ready=0; exactly 3 writes; no FIFO over-pop.
REQ-038 base=0xFFFE, num=4: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-039 data_empty_n low for 5 cycles mid-job: data_read stays 0; job completes correctly after refill.
REQ-040 reset asserted during STREAM with valid held: valid=0 and idle=1 next cycle; the next token runs a clean job.
